zx_sync_ctrl: RTL and testbench

//  Controller ahead of the period counter. Qualifies the raw zero-crossing comparator and

---
 rtl/zx_sync_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_zx_sync_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/zx_sync_ctrl.sv
// Zero-crossing qualifier and sync generator ahead of the period counter.
// Optional build macro ZXC_FREEWHEEL_EN: free-running sync in HOLDOVER at the last good period.
module zx_sync_ctrl #(
  parameter int unsigned FILT_LEN = 4,
  parameter logic [15:0] BLANK    = 16'd64,
  parameter logic [15:0] PMIN     = 16'd900,
  parameter logic [15:0] PMAX     = 16'd1300,
  parameter logic [15:0] TOL      = 16'd8,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned MISS_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable12,
  input  logic        comp_in,
  input  logic        clr_stat,
  output logic        zxing,
  output logic        sync,
  output logic        locked,
  output logic        holdover,
  output logic [15:0] status
);

  localparam logic [1:0]  ST_SEARCH   = 2'd0;
  localparam logic [1:0]  ST_ACQUIRE  = 2'd1;
  localparam logic [1:0]  ST_LOCKED   = 2'd2;
  localparam logic [1:0]  ST_HOLDOVER = 2'd3;
  localparam logic [15:0] TMO         = PMAX + 16'd1;
  localparam logic [2:0]  FILT_LAST   = 3'(FILT_LEN - 1);
  localparam logic [3:0]  LOCK_N      = 4'(LOCK_CNT);
  localparam logic [3:0]  MISS_N      = 4'(MISS_MAX);

  logic [1:0]  meta_q;
  logic        filt_lvl;
  logic [2:0]  filt_cnt;
  logic        rise;
  logic [15:0] blank_cnt;
  logic [15:0] tick_cnt;
  logic [15:0] prev_per;
  logic [3:0]  good_cnt, good_nxt;
  logic [3:0]  miss_cnt, miss_nxt;
  logic [7:0]  glitch_cnt;
  logic [1:0]  state, state_nxt;
  logic        sync_pend;
  logic        accept_c, glitch_c, timeout_c, valid_c, sync_req_c;
  logic [15:0] diff_c;
`ifdef ZXC_FREEWHEEL_EN
  logic [15:0] last_good;
`endif

  // Synchronizer and majority-free run-length filter; rise marks a filtered 0->1 edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 2'b00;
      filt_lvl <= 1'b0;
      filt_cnt <= 3'd0;
      rise     <= 1'b0;
    end else begin
      meta_q <= {meta_q[0], comp_in};
      rise   <= 1'b0;
      if (enable12) begin
        if (meta_q[1] != filt_lvl) begin
          if (filt_cnt == FILT_LAST) begin
            filt_lvl <= meta_q[1];
            filt_cnt <= 3'd0;
            rise     <= meta_q[1];
          end else begin
            filt_cnt <= filt_cnt + 3'd1;
          end
        end else begin
          filt_cnt <= 3'd0;
        end
      end
    end
  end

  assign accept_c  = rise && (blank_cnt == 16'd0);
  assign glitch_c  = rise && (blank_cnt != 16'd0);
  assign timeout_c = (tick_cnt == TMO) && !accept_c;
  assign diff_c    = (tick_cnt >= prev_per) ? (tick_cnt - prev_per) : (prev_per - tick_cnt);
  assign valid_c   = (tick_cnt >= PMIN) && (tick_cnt <= PMAX) && (diff_c <= TOL);

  // Period measurement, blanking window and glitch statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_cnt  <= 16'd0;
      tick_cnt   <= 16'd0;
      prev_per   <= 16'd0;
      glitch_cnt <= 8'd0;
    end else begin
      if (accept_c)
        blank_cnt <= BLANK;
      else if (enable12 && blank_cnt != 16'd0)
        blank_cnt <= blank_cnt - 16'd1;
      if (accept_c || timeout_c)
        tick_cnt <= 16'd0;
      else if (enable12 && tick_cnt != 16'hFFFF)
        tick_cnt <= tick_cnt + 16'd1;
      if (accept_c)
        prev_per <= tick_cnt;
      if (clr_stat)
        glitch_cnt <= 8'd0;
      else if (glitch_c && glitch_cnt != 8'hFF)
        glitch_cnt <= glitch_cnt + 8'd1;
    end
  end

`ifdef ZXC_FREEWHEEL_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_good <= 16'd0;
    else if (accept_c && valid_c)
      last_good <= tick_cnt;
  end
`endif

  // Lock state machine: next state, counters and sync request
  always_comb begin
    state_nxt  = state;
    good_nxt   = good_cnt;
    miss_nxt   = miss_cnt;
    sync_req_c = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (accept_c) begin
          state_nxt = ST_ACQUIRE;
          good_nxt  = 4'd0;
        end
      end
      ST_ACQUIRE: begin
        if (accept_c) begin
          if (valid_c) begin
            if (good_cnt + 4'd1 == LOCK_N) begin
              state_nxt  = ST_LOCKED;
              good_nxt   = 4'd0;
              sync_req_c = 1'b1;
            end else begin
              good_nxt = good_cnt + 4'd1;
            end
          end else begin
            good_nxt = 4'd0;
          end
        end else if (timeout_c) begin
          state_nxt = ST_SEARCH;
          good_nxt  = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (accept_c && valid_c) begin
          sync_req_c = 1'b1;
        end else if (accept_c || timeout_c) begin
          state_nxt = ST_HOLDOVER;
          miss_nxt  = 4'd1;
        end
      end
      default: begin
        if (accept_c && valid_c) begin
          state_nxt  = ST_LOCKED;
          miss_nxt   = 4'd0;
          sync_req_c = 1'b1;
        end else if (accept_c || timeout_c) begin
          if (miss_cnt + 4'd1 == MISS_N) begin
            state_nxt = ST_SEARCH;
            miss_nxt  = 4'd0;
          end else begin
            miss_nxt = miss_cnt + 4'd1;
          end
        end
`ifdef ZXC_FREEWHEEL_EN
        else if (enable12 && last_good != 16'd0 && tick_cnt == last_good) begin
          sync_req_c = 1'b1;
        end
`endif
      end
    endcase
  end

  // sync trails zxing by one clk so the period counter has already latched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SEARCH;
      good_cnt  <= 4'd0;
      miss_cnt  <= 4'd0;
      zxing     <= 1'b0;
      sync_pend <= 1'b0;
      sync      <= 1'b0;
      locked    <= 1'b0;
      holdover  <= 1'b0;
      status    <= 16'd0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      miss_cnt  <= miss_nxt;
      zxing     <= accept_c;
      sync_pend <= sync_req_c;
      sync      <= sync_pend;
      locked    <= (state == ST_LOCKED);
      holdover  <= (state == ST_HOLDOVER);
      status    <= {glitch_cnt, miss_cnt, (state == ST_HOLDOVER), (state == ST_LOCKED), state};
    end
  end

endmodule

// File: tb/tb_zx_sync_ctrl.sv
// Directed bench for zx_sync_ctrl: lock, glitch blanking, holdover, loss, acquire reset, reset.
module tb_zx_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable12 = 1'b1;
  logic        comp_in = 1'b0;
  logic        clr_stat = 1'b0;
  logic        zxing, sync, locked, holdover;
  logic [15:0] status;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int zx_n = 0;
  int sy_n = 0;
  int last_zx = 0;
  int last_sy = 0;

  zx_sync_ctrl #(
    .FILT_LEN(2), .BLANK(16'd4), .PMIN(16'd90), .PMAX(16'd110),
    .TOL(16'd2), .LOCK_CNT(3), .MISS_MAX(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable12(enable12), .comp_in(comp_in),
    .clr_stat(clr_stat), .zxing(zxing), .sync(sync), .locked(locked),
    .holdover(holdover), .status(status)
  );

  always #5 clk = ~clk;

  // Pulse recorder sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (zxing) begin zx_n = zx_n + 1; last_zx = cyc; end
    if (sync)  begin sy_n = sy_n + 1; last_sy = cyc; end
  end

  task automatic run(input logic v, input int n);
    comp_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic period();
    run(1'b1, 50);
    run(1'b0, 50);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (zxing !== 1'b0) begin failures++; $display("FAIL reset_zxing got=%b exp=0", zxing); end
    checks++; if (sync !== 1'b0) begin failures++; $display("FAIL reset_sync got=%b exp=0", sync); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (holdover !== 1'b0) begin failures++; $display("FAIL reset_holdover got=%b exp=0", holdover); end
    checks++; if (status !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", status); end
    rst_n = 1'b1;
    run(1'b0, 10);
  endtask

  task automatic test_lock();
    int z0, s0;
    z0 = zx_n; s0 = sy_n;
    repeat (5) period();
    checks++; if (zx_n - z0 !== 5) begin failures++; $display("FAIL lock_zx_count got=%0d exp=5", zx_n - z0); end
    checks++; if (sy_n - s0 !== 1) begin failures++; $display("FAIL lock_sync_count got=%0d exp=1", sy_n - s0); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%b exp=1", locked); end
    checks++; if (status[1:0] !== 2'd2) begin failures++; $display("FAIL lock_state got=%0d exp=2", status[1:0]); end
    checks++; if (last_sy !== last_zx + 1) begin failures++; $display("FAIL lock_sync_lag got=%0d exp=%0d", last_sy, last_zx + 1); end
    repeat (2) period();
    checks++; if (sy_n - s0 !== 3) begin failures++; $display("FAIL locked_sync_count got=%0d exp=3", sy_n - s0); end
    checks++; if (last_sy !== last_zx + 1) begin failures++; $display("FAIL locked_sync_lag got=%0d exp=%0d", last_sy, last_zx + 1); end
  endtask

  task automatic test_glitch();
    int z0;
    z0 = zx_n;
    run(1'b1, 2);
    run(1'b0, 2);
    run(1'b1, 46);
    run(1'b0, 50);
    run(1'b1, 50);
    run(1'b0, 10);
    checks++; if (zx_n - z0 !== 2) begin failures++; $display("FAIL glitch_zx_count got=%0d exp=2", zx_n - z0); end
    checks++; if (status[15:8] !== 8'd1) begin failures++; $display("FAIL glitch_cnt got=%0d exp=1", status[15:8]); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL glitch_locked got=%b exp=1", locked); end
    clr_stat = 1'b1;
    @(posedge clk); #1;
    clr_stat = 1'b0;
    run(1'b0, 39);
    checks++; if (status[15:8] !== 8'd0) begin failures++; $display("FAIL glitch_clear got=%0d exp=0", status[15:8]); end
  endtask

  task automatic test_holdover();
    int s0;
    run(1'b1, 50);
    run(1'b0, 70);
    checks++; if (holdover !== 1'b1) begin failures++; $display("FAIL ho_holdover got=%b exp=1", holdover); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL ho_locked got=%b exp=0", locked); end
    checks++; if (status[7:0] !== 8'h1B) begin failures++; $display("FAIL ho_status got=%h exp=1b", status[7:0]); end
    s0 = sy_n;
    run(1'b0, 92);
    period();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ho_relock got=%b exp=1", locked); end
    checks++; if (status[7:0] !== 8'h06) begin failures++; $display("FAIL ho_relock_status got=%h exp=06", status[7:0]); end
    checks++; if (sy_n - s0 !== 1) begin failures++; $display("FAIL ho_relock_sync got=%0d exp=1", sy_n - s0); end
  endtask

  task automatic test_loss();
    int s0;
    int exp_sync;
`ifdef ZXC_FREEWHEEL_EN
    exp_sync = 1;
`else
    exp_sync = 0;
`endif
    run(1'b1, 50);
    run(1'b0, 70);
    checks++; if (holdover !== 1'b1) begin failures++; $display("FAIL loss_holdover got=%b exp=1", holdover); end
    s0 = sy_n;
    run(1'b0, 130);
    checks++; if (status[7:0] !== 8'h00) begin failures++; $display("FAIL loss_status got=%h exp=00", status[7:0]); end
    checks++; if ({locked, holdover} !== 2'b00) begin failures++; $display("FAIL loss_flags got=%b exp=00", {locked, holdover}); end
    checks++; if (sy_n - s0 !== exp_sync) begin failures++; $display("FAIL loss_sync got=%0d exp=%0d", sy_n - s0, exp_sync); end
  endtask

  task automatic test_acquire();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(1'b0, 10);
    repeat (3) period();
    run(1'b1, 50);
    run(1'b0, 54);
    run(1'b1, 50);
    checks++; if (status[1:0] !== 2'd1) begin failures++; $display("FAIL acq_after_104 got=%0d exp=1", status[1:0]); end
    run(1'b0, 50);
    repeat (2) period();
    run(1'b1, 50);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL acq_early_lock got=%b exp=0", locked); end
    run(1'b0, 50);
    run(1'b1, 50);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL acq_lock got=%b exp=1", locked); end
  endtask

  task automatic test_reset_locked();
    run(1'b0, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if ({zxing, sync, locked, holdover} !== 4'b0000) begin failures++; $display("FAIL rst_locked_flags got=%b exp=0000", {zxing, sync, locked, holdover}); end
    checks++; if (status !== 16'h0000) begin failures++; $display("FAIL rst_locked_status got=%h exp=0000", status); end
    run(1'b0, 5);
    checks++; if (status !== 16'h0000) begin failures++; $display("FAIL rst_idle_status got=%h exp=0000", status); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_lock();
    test_glitch();
    test_holdover();
    test_loss();
    test_acquire();
    test_reset_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
